// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Latency classes describe when each opcode's result becomes visible.
package hazard_pkg;

    localparam int MAX_LAT_DEF = 4;
    localparam int CNT_W       = $clog2(MAX_LAT_DEF + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t wb_cnt;
        cnt_t fwd_cnt;
        cnt_t age;
    } entry_t;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_LW,
        OP_JAL
    } op_cls_e;

    localparam cnt_t ALU_LAT = cnt_t'(2);
    localparam cnt_t ALU_FWD = cnt_t'(0);
    localparam cnt_t LW_LAT  = cnt_t'(3);
    localparam cnt_t LW_FWD  = cnt_t'(2);
    localparam cnt_t JAL_LAT = cnt_t'(3);
    localparam cnt_t JAL_FWD = cnt_t'(3);

    function automatic cnt_t dec_sat(cnt_t c);
        return (c == '0) ? c : c - cnt_t'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/source bundle from decode plus the hazard verdict back to ID.
// master = ID stage, slave = scoreboard.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int AW    = 4,
    parameter int CNT_W = hazard_pkg::CNT_W
);
    localparam int NUM_REGS = 2 ** AW;

    logic                issue_valid;
    logic                issue_wen;
    logic [AW-1:0]       issue_waddr;
    logic [CNT_W-1:0]    issue_lat;
    logic [CNT_W-1:0]    issue_fwd;
    logic                src1_valid;
    logic                src2_valid;
    logic [AW-1:0]       src1_addr;
    logic [AW-1:0]       src2_addr;
    logic                flush;
    logic                stall;
    logic                fwd1;
    logic                fwd2;
    logic [NUM_REGS-1:0] pending;
    logic                busy;

    modport master (
        output issue_valid, issue_wen, issue_waddr,
        output issue_lat, issue_fwd,
        output src1_valid, src2_valid, src1_addr, src2_addr,
        output flush,
        input  stall, fwd1, fwd2, pending, busy
    );

    modport slave (
        input  issue_valid, issue_wen, issue_waddr,
        input  issue_lat, issue_fwd,
        input  src1_valid, src2_valid, src1_addr, src2_addr,
        input  flush,
        output stall, fwd1, fwd2, pending, busy
    );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's outstanding-write tracker: write-back, bypass and age counters.
// A fresh accept is loaded without decrementing in its issue cycle.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int MAX_LAT    = MAX_LAT_DEF,
    parameter int KILL_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic accept_i,
    input  logic flush_i,
    input  cnt_t lat_i,
    input  cnt_t fwd_i,
    output cnt_t wb_o,
    output cnt_t fwd_o
);

    entry_t ent_q, ent_d;
    logic   live;
    logic   kill;

    assign live = (ent_q.wb_cnt != '0);
    assign kill = flush_i && (int'(ent_q.age) < KILL_DEPTH);

    always_comb begin
        ent_d = ent_q;
        if (accept_i) begin
            ent_d.wb_cnt  = lat_i;
            ent_d.fwd_cnt = fwd_i;
            ent_d.age     = '0;
        end else if (live && kill) begin
            ent_d = '0;
        end else if (live) begin
            ent_d.wb_cnt  = dec_sat(ent_q.wb_cnt);
            ent_d.fwd_cnt = dec_sat(ent_q.fwd_cnt);
            if (ent_q.age < cnt_t'(MAX_LAT)) begin
                ent_d.age = ent_q.age + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign wb_o  = ent_q.wb_cnt;
    assign fwd_o = ent_q.fwd_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: per-register pending writes, bypass flags, WAW order, flush.
// Only the source/WAW compare muxes live here; state is in sb_entry.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW         = 4,
    parameter int MAX_LAT    = MAX_LAT_DEF,
    parameter int FWD_EN     = 1,
    parameter int KILL_DEPTH = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);

    localparam int NUM_REGS = 2 ** AW;
    localparam bit FWD      = (FWD_EN != 0);
    localparam bit ZR       = (ZERO_REG != 0);

    cnt_t                wb  [NUM_REGS];
    cnt_t                fc  [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic                hit1, hit2;
    logic                haz1, haz2;
    logic                waw;
    logic                stall;
    logic                accept;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_ent
        sb_entry #(
            .MAX_LAT   (MAX_LAT),
            .KILL_DEPTH(KILL_DEPTH)
        ) u_ent (
            .clk     (clk),
            .rst     (rst),
            .accept_i(accept && (sb.issue_waddr == AW'(r))),
            .flush_i (sb.flush),
            .lat_i   (sb.issue_lat),
            .fwd_i   (sb.issue_fwd),
            .wb_o    (wb[r]),
            .fwd_o   (fc[r])
        );
        assign pend[r] = (wb[r] != '0);
    end

    // Register 0 is hardwired, so it never produces a hit.
    assign hit1 = sb.src1_valid && pend[sb.src1_addr]
               && !(ZR && sb.src1_addr == '0);
    assign hit2 = sb.src2_valid && pend[sb.src2_addr]
               && !(ZR && sb.src2_addr == '0);

    assign haz1 = hit1 && ((fc[sb.src1_addr] != '0) || !FWD);
    assign haz2 = hit2 && ((fc[sb.src2_addr] != '0) || !FWD);

    // A shorter-latency writer would retire ahead of the older one.
    assign waw = sb.issue_wen && pend[sb.issue_waddr]
              && (sb.issue_lat < wb[sb.issue_waddr]);

    assign stall = sb.issue_valid && !sb.flush && (haz1 || haz2 || waw);

    assign accept = sb.issue_valid && sb.issue_wen && !stall && !sb.flush
                 && !(ZR && sb.issue_waddr == '0);

    assign sb.stall   = stall;
    assign sb.fwd1    = hit1 && FWD && (fc[sb.src1_addr] == '0);
    assign sb.fwd2    = hit2 && FWD && (fc[sb.src2_addr] == '0);
    assign sb.pending = pend;
    assign sb.busy    = |pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; stimulus queues expectations, a monitor checks.
// Instance a forwards on bypass hits, instance b waits for write-back.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk;
    logic rst;

    hazard_scoreboard_if #(.AW(4), .CNT_W(CNT_W)) ia ();
    hazard_scoreboard_if #(.AW(4), .CNT_W(CNT_W)) ib ();

    hazard_scoreboard #(.FWD_EN(1)) dut_a (
        .clk(clk),
        .rst(rst),
        .sb (ia)
    );

    hazard_scoreboard #(.FWD_EN(0)) dut_b (
        .clk(clk),
        .rst(rst),
        .sb (ib)
    );

    typedef struct {
        string       nm;
        bit          sel;
        bit          st;
        bit          f1;
        bit          f2;
        bit          cf;
        logic [15:0] pend;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, string f,
                                logic [15:0] act, logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, want);
        end
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
                chk(e.nm, "stall", 16'(ib.stall), 16'(e.st));
                chk(e.nm, "pend", ib.pending, e.pend);
                chk(e.nm, "busy", 16'(ib.busy), 16'(|e.pend));
                if (e.cf) begin
                    chk(e.nm, "fwd1", 16'(ib.fwd1), 16'(e.f1));
                    chk(e.nm, "fwd2", 16'(ib.fwd2), 16'(e.f2));
                end
            end else begin
                chk(e.nm, "stall", 16'(ia.stall), 16'(e.st));
                chk(e.nm, "pend", ia.pending, e.pend);
                chk(e.nm, "busy", 16'(ia.busy), 16'(|e.pend));
                if (e.cf) begin
                    chk(e.nm, "fwd1", 16'(ia.fwd1), 16'(e.f1));
                    chk(e.nm, "fwd2", 16'(ia.fwd2), 16'(e.f2));
                end
            end
        end
    end

    task automatic drive(input bit sel, input bit v, input bit wen,
                         input logic [3:0] w, input logic [2:0] lat,
                         input logic [2:0] fw,
                         input bit s1v, input logic [3:0] s1,
                         input bit s2v, input logic [3:0] s2,
                         input bit fl);
        ia.issue_valid = v && !sel;
        ib.issue_valid = v && sel;
        ia.src1_valid  = s1v && !sel;
        ib.src1_valid  = s1v && sel;
        ia.src2_valid  = s2v && !sel;
        ib.src2_valid  = s2v && sel;
        ia.flush       = fl && !sel;
        ib.flush       = fl && sel;
        ia.issue_wen   = wen;
        ib.issue_wen   = wen;
        ia.issue_waddr = w;
        ib.issue_waddr = w;
        ia.issue_lat   = lat;
        ib.issue_lat   = lat;
        ia.issue_fwd   = fw;
        ib.issue_fwd   = fw;
        ia.src1_addr   = s1;
        ib.src1_addr   = s1;
        ia.src2_addr   = s2;
        ib.src2_addr   = s2;
    endtask

    task automatic step(input string nm, input bit sel,
                        input bit v, input bit wen, input logic [3:0] w,
                        input logic [2:0] lat, input logic [2:0] fw,
                        input bit s1v, input logic [3:0] s1,
                        input bit s2v, input logic [3:0] s2,
                        input bit fl,
                        input bit st, input bit f1, input bit f2,
                        input bit cf, input logic [15:0] pend);
        @(posedge clk);
        #1;
        drive(sel, v, wen, w, lat, fw, s1v, s1, s2v, s2, fl);
        q.push_back('{nm, sel, st, f1, f2, cf, pend});
    endtask

    task automatic idle(input string nm, input bit sel,
                        input logic [15:0] pend);
        step(nm, sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pend);
    endtask

    initial begin
        rst = 1'b0;
        #2;
        drive(0, 1, 1, 3, 2, 0, 1, 3, 1, 3, 0);
        q.push_back('{"rst_a", 0, 0, 0, 0, 1, 16'h0000});
        q.push_back('{"rst_b", 1, 0, 0, 0, 1, 16'h0000});
        @(negedge clk);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // ALU to R3, consumer one cycle later takes the bypass
        step("alu_iss", 0, 1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step("alu_use", 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 1, 16'h0008);
        idle("alu_wb1", 0, 16'h0008);
        idle("alu_clr", 0, 16'h0000);

        // Load-use on src2
        step("lw_iss", 0, 1, 1, 5, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step("lw_st1", 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 16'h0020);
        step("lw_st2", 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 16'h0020);
        step("lw_byp", 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 1, 16'h0020);
        idle("lw_clr", 0, 16'h0000);

        // WAW: shorter ALU waits behind the LW
        step("waw_lw", 0, 1, 1, 7, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step("waw_st", 0, 1, 1, 7, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0080);
        step("waw_acc", 0, 1, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0080);
        idle("waw_t1", 0, 16'h0080);
        idle("waw_t2", 0, 16'h0080);
        idle("waw_clr", 0, 16'h0000);

        // Flush: R2/R4 young, R9 at age 2 survives, R6 not recorded
        step("fl_r9", 0, 1, 1, 9, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step("fl_r2", 0, 1, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0200);
        step("fl_r4", 0, 1, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0204);
        step("fl_go", 0, 1, 1, 6, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0214);
        idle("fl_old", 0, 16'h0200);
        idle("fl_clr", 0, 16'h0000);

        // Register 0 is never tracked
        step("r0_wr", 0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step("r0_rd", 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0000);
        idle("r0_clr", 0, 16'h0000);

        // No forwarding: stall until write-back completes
        step("nf_iss", 1, 1, 1, 5, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step("nf_st1", 1, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 16'h0020);
        step("nf_st2", 1, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 16'h0020);
        step("nf_st3", 1, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 0, 16'h0020);
        step("nf_go", 1, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 16'h0000);

        // Asynchronous reset mid-count
        step("rs_iss", 0, 1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        idle("rs_pend", 0, 16'h0008);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        #1;
        rst = 1'b0;
        q.push_back('{"rs_drop", 0, 0, 0, 0, 1, 16'h0000});
        @(negedge clk);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        idle("rs_after", 0, 16'h0000);
        idle("rs_end", 0, 16'h0000);

        repeat (3) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
